// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: op codes,
// default latencies and the IDLE/RUN state type. MDU_MADD_EN enables madd/msub codes.
package mdu_unit_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_unit_if.sv
// Operand/result bundle between the E-stage and the multiply/divide unit.
interface mdu_unit_if;
    import mdu_unit_pkg::*;

    // Handshake: start is the valid qualifying op/A/B; the unit is ready when
    // busy=0 and accepts at that rising edge. start while busy=1 is dropped.
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;
    mdu_state_e  dbg_state;

    modport master (output start, op, A, B, input busy, hi, lo, out, dbg_state);
    modport slave  (input start, op, A, B, output busy, hi, lo, out, dbg_state);

endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS HI/LO unit: result computed at launch, committed when the
// latency counter expires. Define MDU_MADD_EN to decode madd/maddu/msub/msubu.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    mdu_unit_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      phi_q, phi_d, plo_q, plo_d;
    logic             pwe_q, pwe_d;

    logic             is_mult, is_div, launch, div_signed;
    logic [63:0]      prod_s, prod_u;
    logic [31:0]      a_mag, b_mag, b_safe, q_mag, r_mag, q_res, r_res;

    always_comb begin
        is_mult = 1'b0;
        is_div  = 1'b0;
        case (bus.op)
            OP_MULT, OP_MULTU: is_mult = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mult = 1'b1;
`endif
            OP_DIV, OP_DIVU: is_div = 1'b1;
            default: ;
        endcase
    end

    assign launch = bus.start && (state_q == ST_IDLE) && (is_mult || is_div);

    // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
    always_comb begin
        prod_s     = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
        prod_u     = {32'd0, bus.A} * {32'd0, bus.B};
        div_signed = (bus.op == OP_DIV);
        a_mag      = (div_signed && bus.A[31]) ? -bus.A : bus.A;
        b_mag      = (div_signed && bus.B[31]) ? -bus.B : bus.B;
        b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        q_res      = (div_signed && (bus.A[31] ^ bus.B[31])) ? -q_mag : q_mag;
        r_res      = (div_signed && bus.A[31]) ? -r_mag : r_mag;
    end

    always_comb begin
        phi_d = phi_q;
        plo_d = plo_q;
        pwe_d = pwe_q;
        if (launch) begin
            pwe_d = 1'b1;
            case (bus.op)
                OP_MULT:  {phi_d, plo_d} = prod_s;
                OP_MULTU: {phi_d, plo_d} = prod_u;
`ifdef MDU_MADD_EN
                OP_MADD:  {phi_d, plo_d} = {hi_q, lo_q} + prod_s;
                OP_MADDU: {phi_d, plo_d} = {hi_q, lo_q} + prod_u;
                OP_MSUB:  {phi_d, plo_d} = {hi_q, lo_q} - prod_s;
                OP_MSUBU: {phi_d, plo_d} = {hi_q, lo_q} - prod_u;
`endif
                default: begin
                    phi_d = r_res;
                    plo_d = q_res;
                    pwe_d = (bus.B != 32'd0);
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (state_q == ST_RUN) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1) && pwe_q) begin
                hi_d = phi_q;
                lo_d = plo_q;
            end
        end else if (launch) begin
            cnt_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (bus.start && bus.op == OP_MTHI) begin
            hi_d = bus.A;
        end else if (bus.start && bus.op == OP_MTLO) begin
            lo_d = bus.A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwe_q   <= pwe_d;
        end
    end

    always_comb begin
        bus.busy      = (state_q == ST_RUN);
        bus.hi        = hi_q;
        bus.lo        = lo_q;
        bus.dbg_state = state_q;
        case (bus.op)
            OP_MFHI: bus.out = hi_q;
            OP_MFLO: bus.out = lo_q;
            default: bus.out = 32'd0;
        endcase
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Consumes the forwarded E-stage operands, i.e. rs/rt after the E-stage forwarding muxes.
- Holds architectural HI/LO and models multi-cycle latency with a down-counter.
- Exposes `busy` so the stall logic can freeze D when an MDU instruction is in decode.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd-family when enabled).
- DIV_CYCLES, 10: busy cycles for div/divu.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  E-stage instruction is an MDU op; qualifies op
- op  in  4  MDU opcode (macro-header encoding)
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- busy  out  1  multi-cycle op in progress
- hi  out  32  current HI register
- lo  out  32  current LO register
- out  out  32  mfhi/mflo result to E/M register

Behaviour:
- Reset (async, active-high): hi=0, lo=0, busy=0, counter=0, pending regs=0. Reset mid-operation aborts it and no HI/LO write occurs.
- Ops: NONE=0, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO (+MADD, MADDU, MSUB, MSUBU when feature enabled).
- States: IDLE (counter=0, busy=0) and RUN (counter>0, busy=1).
- Launch: op sampled at the rising edge where start=1 and busy=0.
  - Result is computed at launch into pending_hi/pending_lo.
  - counter loads MULT_CYCLES or DIV_CYCLES.
  - busy rises the cycle after the launch edge and stays high exactly CYCLES cycles.
  - At the edge where counter goes 1->0, hi/lo take the pending values and busy falls.
  - Launch at edge N -> new hi/lo visible after edge N+CYCLES.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 -> 64.
  - div: signed; lo=quotient truncated toward zero; hi=remainder carrying the dividend's sign.
  - divu: unsigned.
- Boundaries:
  - Divide by zero (B=0, div or divu): op still occupies DIV_CYCLES, but hi/lo are left unchanged.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO: with busy=0, written at the same edge: hi<=A or lo<=A. busy never asserts.
- MFHI/MFLO: combinational; out=hi or lo, valid whenever busy=0. out=0 for any other op.
- start while busy=1: ignored entirely (stall unit guarantees it does not occur). hi/lo and counter are unaffected.
- start=0: no state change except counter progression.
- Reads during busy return the old hi/lo. Stall logic must block mf*/mt*/mult*/div* in D while (busy | start).

Optional Feature:
- Macro: MDU_MADD_EN
- Defined: MADD/MADDU/MSUB/MSUBU are decoded.
  - {hi,lo} ± A*B, signed or unsigned per op.
  - Accumulation uses the {hi,lo} value at launch; latency MULT_CYCLES.
- Undefined: those codes are treated as NONE: no busy, no state change.

Decomposition:
- Shared macro header (alongside the existing forward-select macros):
  - MDU op codes.
  - MULT_CYCLES/DIV_CYCLES defaults.
- Single module; no sub-module is needed.
  - Datapath is one combinational compute block feeding pending registers.
  - A separate latency counter would add nothing.

Test Plan:
- reset asserted mid-div (cycle 4 of 10) -> busy=0, hi=lo=0 asynchronously; no later write.
- mult A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div A=-7, B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1) after 10 busy cycles. divu A=7, B=0 after mthi 0x11 / mtlo 0x22 -> hi=0x11, lo=0x22, busy 10 cycles.
- mtlo A=0x1234 then mflo same cycle-next -> out=0x1234, busy never 1. start with mult while busy -> ignored, counter and hi/lo unchanged.
- div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. mfhi during busy -> returns previous hi.
- MDU_MADD_EN: hi=0, lo=5, madd A=2, B=3 -> lo=11 after 5 cycles. Without macro, same code -> busy stays 0, lo=5.
